// File: rtl/mem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them to
// consecutive data-memory addresses while holding the CPU in reset. Optional: MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cpu_reset,
    output logic             Ext_MemWrite,
    output logic [31:0]      Ext_WriteData,
    output logic [31:0]      Ext_DataAdr,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic [1:0]       lane_cnt;
    logic             load_start;

    assign load_start = start && (state == IDLE || state == RUN);

    // Ext_DataAdr doubles as the address register and Ext_WriteData as the word assembly buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cpu_reset     <= 1'b1;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= 32'h0;
            Ext_DataAdr   <= 32'h0;
            words_left    <= '0;
            lane_cnt      <= 2'd0;
        end else begin
            done         <= 1'b0;
            Ext_MemWrite <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        Ext_DataAdr <= base_adr & 32'hFFFF_FFFC;
                        words_left  <= word_count;
                        lane_cnt    <= 2'd0;
                        if (word_count != '0) begin
                            state     <= LOAD;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                            cpu_reset <= 1'b1;
                        end else begin
                            state     <= RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end
                    end else if (run && state == IDLE) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        Ext_WriteData[8*lane_cnt +: 8] <= in_data;
                        lane_cnt <= lane_cnt + 2'd1;
                        if (lane_cnt == 2'd3) begin
                            state        <= WRITE;
                            in_ready     <= 1'b0;
                            Ext_MemWrite <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    Ext_DataAdr <= Ext_DataAdr + 32'd4;
                    words_left  <= words_left - CNT_W'(1);
                    if (words_left == CNT_W'(1)) begin
                        state     <= RUN;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Folded in on the WRITE exit edge, i.e. once per word actually written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= 32'h0;
        end else if (load_start) begin
            checksum <= 32'h0;
        end else if (state == WRITE) begin
            checksum <= checksum ^ Ext_WriteData;
        end
    end
`else
    assign checksum = 32'h0;
`endif

endmodule
